// File: rtl/gcore_led_pkg.sv
// Shared types and elaboration-time helpers for the LED scan multiplexer.
package gcore_led_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SHOW = 2'd1,
        ST_GAP  = 2'd2
    } scan_state_e;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            r = r + 1;
        end
        return r;
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // A channel index always needs at least one bit, even for a single channel.
    function automatic int idx_width(input int channels);
        return (clog2(channels) < 1) ? 1 : clog2(channels);
    endfunction

    // Level of a select line that is switched off.
    function automatic logic sel_off_bit(input bit active_low);
        return active_low ? 1'b1 : 1'b0;
    endfunction

endpackage

// File: rtl/led_scan_timer.sv
// Loadable down-counter shared by the dwell and blanking phases; saturates at zero.
module led_scan_timer #(
    parameter int CW = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load_i,
    input  logic [CW-1:0] value_i,
    output logic          zero_o
);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = value_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/led_scan_mux.sv
// Time-multiplexed LED driver: scans a per-frame snapshot of CHANNELS words onto
// one registered LED bus with a one-hot select, optional blanking between channels.
module led_scan_mux
    import gcore_led_pkg::*;
#(
    parameter int WIDTH          = 8,
    parameter int CHANNELS       = 2,
    parameter int DWELL          = 1,
    parameter int BLANK          = 0,
    parameter bit SEL_ACTIVE_LOW = 1'b0,
    localparam int IDX_W         = idx_width(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic [CHANNELS*WIDTH-1:0] ch_data,
    output logic [WIDTH-1:0]          out,
    output logic [CHANNELS-1:0]       sel,
    output logic [IDX_W-1:0]          sel_idx,
    output logic                      frame_start
);

    localparam int CW                     = clog2(max_int(DWELL, BLANK)) + 1;
    localparam bit HAS_GAP                = (BLANK > 0);
    localparam logic [CHANNELS-1:0] SEL_OFF = {CHANNELS{sel_off_bit(SEL_ACTIVE_LOW)}};
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CHANNELS - 1);
    localparam logic [CW-1:0] DWELL_LOAD  = CW'(DWELL - 1);
    localparam logic [CW-1:0] BLANK_LOAD  = HAS_GAP ? CW'(BLANK - 1) : '0;

    scan_state_e               state_q, state_d;
    logic [IDX_W-1:0]          idx_q, idx_d;
    logic [CHANNELS*WIDTH-1:0] snap_q, snap_d;
    logic [WIDTH-1:0]          out_q, out_d;
    logic [CHANNELS-1:0]       sel_q, sel_d;
    logic                      fs_q, fs_d;

    logic                      tmr_load;
    logic [CW-1:0]             tmr_value;
    logic                      tmr_zero;

    logic                      start_scan;
    logic                      advance;
    logic                      wrap;
    logic                      enter_gap;
    logic [IDX_W-1:0]          idx_inc;
    logic [WIDTH-1:0]          snap_words [CHANNELS];

    generate
        for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_unpack
            assign snap_words[gi] = snap_q[gi*WIDTH +: WIDTH];
        end
    endgenerate

    function automatic logic [CHANNELS-1:0] sel_code(input logic [IDX_W-1:0] i);
        return (CHANNELS'(1) << i) ^ SEL_OFF;
    endfunction

    led_scan_timer #(
        .CW(CW)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .load_i  (tmr_load),
        .value_i (tmr_value),
        .zero_o  (tmr_zero)
    );

    // Phase-end events; all of them are suppressed when en is low.
    assign start_scan = en && (state_q == ST_IDLE);
    assign enter_gap  = en && HAS_GAP && (state_q == ST_SHOW) && tmr_zero;
    assign advance    = en && tmr_zero &&
                        (((state_q == ST_SHOW) && !HAS_GAP) || (state_q == ST_GAP));
    assign wrap       = advance && (idx_q == LAST_IDX);
    assign idx_inc    = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (!en) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: state_d = ST_SHOW;
                ST_SHOW: if (enter_gap) state_d = ST_GAP;
                ST_GAP:  if (advance) state_d = ST_SHOW;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Output/datapath next values; a wrap reuses the start path so frames are gapless.
    always_comb begin
        idx_d     = idx_q;
        snap_d    = snap_q;
        out_d     = out_q;
        sel_d     = sel_q;
        fs_d      = 1'b0;
        tmr_load  = 1'b0;
        tmr_value = '0;
        if (!en) begin
            idx_d    = '0;
            snap_d   = '0;
            out_d    = '0;
            sel_d    = SEL_OFF;
            tmr_load = 1'b1;
        end else if (start_scan || wrap) begin
            idx_d     = '0;
            snap_d    = ch_data;
            out_d     = ch_data[WIDTH-1:0];
            sel_d     = sel_code('0);
            fs_d      = 1'b1;
            tmr_load  = 1'b1;
            tmr_value = DWELL_LOAD;
        end else if (advance) begin
            idx_d     = idx_inc;
            out_d     = snap_words[idx_inc];
            sel_d     = sel_code(idx_inc);
            tmr_load  = 1'b1;
            tmr_value = DWELL_LOAD;
        end else if (enter_gap) begin
            out_d     = '0;
            sel_d     = SEL_OFF;
            tmr_load  = 1'b1;
            tmr_value = BLANK_LOAD;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q  <= '0;
            snap_q <= '0;
            out_q  <= '0;
            sel_q  <= SEL_OFF;
            fs_q   <= 1'b0;
        end else begin
            idx_q  <= idx_d;
            snap_q <= snap_d;
            out_q  <= out_d;
            sel_q  <= sel_d;
            fs_q   <= fs_d;
        end
    end

    assign out         = out_q;
    assign sel         = sel_q;
    assign sel_idx     = idx_q;
    assign frame_start = fs_q;

endmodule

// File: tb/tb_led_scan_mux.sv
// Directed bench for led_scan_mux in three configurations: default, 3ch/dwell2/blank1,
// and 4ch active-low select with blanking.
`timescale 1ns/1ps
module tb_led_scan_mux;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Config A: defaults
    logic        en_a = 1'b0;
    logic [15:0] data_a = '0;
    logic [7:0]  out_a;
    logic [1:0]  sel_a;
    logic [0:0]  idx_a;
    logic        fs_a;

    // Config B: 3 channels, DWELL=2, BLANK=1
    logic        en_b = 1'b0;
    logic [23:0] data_b = '0;
    logic [7:0]  out_b;
    logic [2:0]  sel_b;
    logic [1:0]  idx_b;
    logic        fs_b;

    // Config C: 4 channels, DWELL=1, BLANK=1, active-low select
    logic        en_c = 1'b0;
    logic [31:0] data_c = '0;
    logic [7:0]  out_c;
    logic [3:0]  sel_c;
    logic [1:0]  idx_c;
    logic        fs_c;

    led_scan_mux u_dut_a (
        .clk(clk), .rst(rst), .en(en_a), .ch_data(data_a),
        .out(out_a), .sel(sel_a), .sel_idx(idx_a), .frame_start(fs_a)
    );

    led_scan_mux #(.WIDTH(8), .CHANNELS(3), .DWELL(2), .BLANK(1), .SEL_ACTIVE_LOW(1'b0)) u_dut_b (
        .clk(clk), .rst(rst), .en(en_b), .ch_data(data_b),
        .out(out_b), .sel(sel_b), .sel_idx(idx_b), .frame_start(fs_b)
    );

    led_scan_mux #(.WIDTH(8), .CHANNELS(4), .DWELL(1), .BLANK(1), .SEL_ACTIVE_LOW(1'b1)) u_dut_c (
        .clk(clk), .rst(rst), .en(en_c), .ch_data(data_c),
        .out(out_c), .sel(sel_c), .sel_idx(idx_c), .frame_start(fs_c)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end else begin
            $display("ok   %s = %0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] words_b1 [3];
        logic [7:0] words_b2 [3];
        logic [7:0] words_c  [4];
        logic [7:0] exp_out;
        logic [7:0] exp_sel;
        logic [7:0] exp_idx;
        int pos;

        words_b1 = '{8'h11, 8'h22, 8'h33};
        words_b2 = '{8'h77, 8'h22, 8'h44};
        words_c  = '{8'h11, 8'h22, 8'h33, 8'h44};

        // Reset state of all three instances
        repeat (2) tick();
        check("a_rst_out", out_a, 8'h00);
        check("a_rst_sel", sel_a, 2'b00);
        check("a_rst_idx", idx_a, 1'b0);
        check("a_rst_fs",  fs_a,  1'b0);
        check("b_rst_sel", sel_b, 3'b000);
        check("c_rst_sel", sel_c, 4'hF);
        check("c_rst_out", out_c, 8'h00);
        rst = 1'b0;
        tick();
        check("a_idle_out", out_a, 8'h00);

        // A: alternating two-channel scan
        data_a = {8'h5A, 8'hA5};
        en_a   = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("a_scan_out", out_a, (i % 2 == 0) ? 8'hA5 : 8'h5A);
            check("a_scan_sel", sel_a, (i % 2 == 0) ? 2'b01 : 2'b10);
            check("a_scan_idx", idx_a, (i % 2 == 0) ? 1'b0 : 1'b1);
            check("a_scan_fs",  fs_a,  (i % 2 == 0) ? 1'b1 : 1'b0);
        end

        // A: en drop during channel 1, then re-enable
        en_a = 1'b0;
        tick();
        check("a_off_out", out_a, 8'h00);
        check("a_off_sel", sel_a, 2'b00);
        check("a_off_fs",  fs_a,  1'b0);
        en_a = 1'b1;
        tick();
        check("a_re_out", out_a, 8'hA5);
        check("a_re_sel", sel_a, 2'b01);
        check("a_re_fs",  fs_a,  1'b1);
        tick();
        check("a_re2_out", out_a, 8'h5A);

        // A: asynchronous reset between edges
        rst = 1'b1;
        #2;
        check("a_arst_out", out_a, 8'h00);
        check("a_arst_sel", sel_a, 2'b00);
        check("a_arst_idx", idx_a, 1'b0);
        tick();
        check("a_rsthold_out", out_a, 8'h00);
        rst = 1'b0;
        tick();
        check("a_rel_out", out_a, 8'hA5);
        check("a_rel_fs",  fs_a,  1'b1);
        tick();
        check("a_rel2_out", out_a, 8'h5A);
        en_a = 1'b0;
        tick();

        // B: two full frames with blanking
        data_b = {8'h33, 8'h22, 8'h11};
        en_b   = 1'b1;
        for (int i = 0; i < 18; i++) begin
            tick();
            pos = i % 9;
            exp_out = (pos % 3 == 2) ? 8'h00 : words_b1[pos / 3];
            exp_idx = 8'(pos / 3);
            exp_sel = (pos % 3 == 2) ? 8'h00 : 8'(1 << (pos / 3));
            check("b_frame_out", out_b, exp_out);
            check("b_frame_idx", idx_b, exp_idx);
            check("b_frame_sel", sel_b, exp_sel);
            check("b_frame_fs",  fs_b,  (pos == 0) ? 1'b1 : 1'b0);
        end

        // B: snapshot isolation - data changes during channel-1 dwell
        en_b = 1'b0;
        tick();
        check("b_off_out", out_b, 8'h00);
        en_b = 1'b1;
        for (int i = 0; i < 18; i++) begin
            tick();
            if (i == 3) data_b = {8'h44, 8'h22, 8'h77};
            pos = i % 9;
            if (i < 9) exp_out = (pos % 3 == 2) ? 8'h00 : words_b1[pos / 3];
            else       exp_out = (pos % 3 == 2) ? 8'h00 : words_b2[pos / 3];
            check("b_snap_out", out_b, exp_out);
            check("b_snap_fs",  fs_b,  (pos == 0) ? 1'b1 : 1'b0);
        end
        en_b = 1'b0;
        tick();

        // C: active-low select, 8-cycle frames
        data_c = {8'h44, 8'h33, 8'h22, 8'h11};
        en_c   = 1'b1;
        for (int i = 0; i < 16; i++) begin
            tick();
            pos = i % 8;
            exp_out = (pos % 2 == 1) ? 8'h00 : words_c[pos / 2];
            exp_sel = (pos % 2 == 1) ? 8'h0F : (~8'(1 << (pos / 2)) & 8'h0F);
            check("c_scan_out", out_c, exp_out);
            check("c_scan_sel", sel_c, exp_sel);
            check("c_scan_idx", idx_c, 8'(pos / 2));
            check("c_scan_fs",  fs_c,  (pos == 0) ? 1'b1 : 1'b0);
            if (pos == 4) check("c_ch2_sel", sel_c, 4'hB);
        end
        en_c = 1'b0;
        tick();
        check("c_off_sel", sel_c, 4'hF);
        check("c_off_out", out_c, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
